// File: rtl/fadd_acc_if.sv
// fadd_acc_if: element stream in, sum stream out, and the operand/result port to the fadd.
interface fadd_acc_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_flag;
  logic        add_req;
  logic [31:0] add_x;
  logic [31:0] add_y;
  logic [31:0] add_rslt;
  logic [4:0]  add_flag;

  modport slave (
    input  in_valid, in_data, in_last, out_ready, add_rslt, add_flag,
    output in_ready, out_valid, out_data, out_flag, add_req, add_x, add_y
  );

  modport master (
    output in_valid, in_data, in_last, out_ready, add_rslt, add_flag,
    input  in_ready, out_valid, out_data, out_flag, add_req, add_x, add_y
  );
endinterface

// File: rtl/fadd_acc.sv
// fadd_acc: float32 packet accumulator driving a pipelined fadd of latency LAT.
// Define FADD_ACC_FTZ_EN to flush subnormal inputs and adder results to signed zero.
module fadd_acc #(
  parameter int unsigned LAT = 3
) (
  input  logic      clk,
  input  logic      reset,
  fadd_acc_if.slave bus
);
  localparam int unsigned CW = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [2:0] {IDLE, ACCUM, ISSUE, WAIT, OUT} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic [31:0]   acc;
  logic [31:0]   ax;
  logic [31:0]   ay;
  logic [4:0]    sticky;
  logic          last_q;
  logic [31:0]   in_fz;
  logic [31:0]   rslt_fz;
  logic [4:0]    flag_fz;

`ifdef FADD_ACC_FTZ_EN
  function automatic logic is_sub(input logic [31:0] v);
    return (v[30:23] == 8'h00) && (v[22:0] != '0);
  endfunction

  // A flushed result is both inexact and an underflow.
  always_comb begin
    in_fz   = is_sub(bus.in_data)  ? {bus.in_data[31], 31'h0}  : bus.in_data;
    rslt_fz = is_sub(bus.add_rslt) ? {bus.add_rslt[31], 31'h0} : bus.add_rslt;
    flag_fz = is_sub(bus.add_rslt) ? (bus.add_flag | 5'b00011) : bus.add_flag;
  end
`else
  assign in_fz   = bus.in_data;
  assign rslt_fz = bus.add_rslt;
  assign flag_fz = bus.add_flag;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx      = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.add_req   = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_nx = bus.in_last ? OUT : ACCUM;
      end
      ACCUM: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_nx = ISSUE;
      end
      ISSUE: begin
        bus.add_req = 1'b1;
        state_nx    = WAIT;
      end
      WAIT: begin
        if (cnt == '0) state_nx = last_q ? OUT : ACCUM;
      end
      OUT: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Operands stay put until capture: the adder re-reads them in its last stage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc    <= '0;
      sticky <= '0;
      ax     <= '0;
      ay     <= '0;
      last_q <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          acc    <= in_fz;
          sticky <= '0;
        end
        ACCUM: if (bus.in_valid) begin
          ax     <= acc;
          ay     <= in_fz;
          last_q <= bus.in_last;
        end
        ISSUE: cnt <= CW'(LAT - 1);
        WAIT: begin
          if (cnt == '0) begin
            acc    <= rslt_fz;
            sticky <= sticky | flag_fz;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.add_x    = ax;
  assign bus.add_y    = ay;
  assign bus.out_data = (state == OUT) ? acc : '0;
  assign bus.out_flag = (state == OUT) ? sticky : '0;
endmodule

// File: tb/tb_fadd_acc.sv
// tb_fadd_acc: randomized packets against a packet-level fold model, plus the directed float vectors.
module tb_fadd_acc;
  localparam int unsigned LAT = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   acnt = 0;
  int   req_log[$];
  logic [31:0] pkt[$];
  logic [31:0] got_sum;
  logic [4:0]  got_flag;

  fadd_acc_if bus();

  fadd_acc #(.LAT(LAT)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Known IEEE sums for the directed vectors; other operand pairs get a surrogate result.
  function automatic logic [36:0] fadd_model(input logic [31:0] x, input logic [31:0] y);
    case ({x, y})
      {32'h3F800000, 32'h40000000}: return {5'h00, 32'h40400000};
      {32'h40400000, 32'h40400000}: return {5'h00, 32'h40C00000};
      {32'h7F800000, 32'hFF800000}: return {5'h10, 32'hFFC00000};
      {32'h7F7FFFFF, 32'h7F7FFFFF}: return {5'h05, 32'h7F800000};
      {32'h40000000, 32'h40000000}: return {5'h00, 32'h40800000};
      {32'h00000001, 32'h00000001}: return {5'h00, 32'h00000002};
      default: return {(x[4:0] ^ y[9:5]) & 5'b10111, x + y};
    endcase
  endfunction

  // Result is only valid LAT cycles after add_req, computed from the operands present then.
  always @(posedge clk) begin
    if (bus.add_req)   acnt <= int'(LAT);
    else if (acnt != 0) acnt <= acnt - 1;
  end

  always @* begin
    if (acnt == 1) {bus.add_flag, bus.add_rslt} = fadd_model(bus.add_x, bus.add_y);
    else           {bus.add_flag, bus.add_rslt} = {5'h1F, 32'hDEADBEEF};
  end

  always @(negedge clk) if (bus.add_req) req_log.push_back(cyc);

  function automatic logic [31:0] ftz(input logic [31:0] v);
`ifdef FADD_ACC_FTZ_EN
    if (v[30:23] == 8'h00 && v[22:0] != 23'h0) return {v[31], 31'h0};
`endif
    return v;
  endfunction

  function automatic logic [36:0] ref_sum(input logic [31:0] p[$]);
    logic [31:0] s;
    logic [4:0]  fl;
    logic [36:0] r;
    s  = ftz(p[0]);
    fl = 5'h00;
    for (int i = 1; i < p.size(); i++) begin
      r  = fadd_model(s, ftz(p[i]));
      fl = fl | r[36:32];
      if (ftz(r[31:0]) != r[31:0]) fl = fl | 5'b00011;
      s  = ftz(r[31:0]);
    end
    return {fl, s};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_tests++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, expv);
    end
  endtask

  task automatic run_pkt(input int hold);
    int          acc_cyc[$];
    int          n;
    int          budget;
    logic [36:0] expv;
    logic [31:0] d0;
    logic [4:0]  f0;
    n    = pkt.size();
    expv = ref_sum(pkt);
    req_log.delete();
    for (int i = 0; i < n; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = pkt[i];
      bus.in_last  = (i == n - 1);
      budget = 0;
      while (!bus.in_ready && budget < 50) begin
        @(posedge clk); #1;
        budget++;
      end
      if (!bus.in_ready) begin
        check("accept_timeout", 32'd0, 32'd1);
        bus.in_valid = 1'b0;
        return;
      end
      acc_cyc.push_back(cyc);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.in_last  = 1'($urandom_range(0, 1));
      bus.in_data  = $urandom;
      if (i != n - 1) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    budget = 0;
    while (!bus.out_valid && budget < 50) begin
      @(posedge clk); #1;
      budget++;
    end
    if (!bus.out_valid) begin
      check("out_valid_timeout", 32'd0, 32'd1);
      return;
    end
    check("out_valid_lat", cyc, acc_cyc[n-1] + ((n == 1) ? 1 : 2 + int'(LAT)));
    check("add_req_count", req_log.size(), n - 1);
    for (int k = 0; k < req_log.size() && k + 1 < n; k++)
      check("add_req_time", req_log[k], acc_cyc[k+1] + 1);
    for (int k = 1; k + 1 < n; k++)
      check("elem_interval", acc_cyc[k+1] - acc_cyc[k], LAT + 2);
    d0 = bus.out_data;
    f0 = bus.out_flag;
    repeat (hold) begin
      @(posedge clk); #1;
      check("bp_valid", bus.out_valid, 1);
      check("bp_data", bus.out_data, d0);
      check("bp_flag", bus.out_flag, f0);
      check("bp_in_ready", bus.in_ready, 0);
    end
    check("sum_data", bus.out_data, expv[31:0]);
    check("sum_flag", bus.out_flag, expv[36:32]);
    check("in_ready_out", bus.in_ready, 0);
    got_sum  = bus.out_data;
    got_flag = bus.out_flag;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("post_valid", bus.out_valid, 0);
    check("post_ready", bus.in_ready, 1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"}, bus.in_ready, 1);
    check({tag, "_out_valid"}, bus.out_valid, 0);
    check({tag, "_out_data"}, bus.out_data, 0);
    check({tag, "_out_flag"}, bus.out_flag, 0);
    check({tag, "_add_req"}, bus.add_req, 0);
    check({tag, "_add_x"}, bus.add_x, 0);
    check({tag, "_add_y"}, bus.add_y, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] e;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("rst");
    reset = 1'b1;
    @(posedge clk); #1;

    pkt = '{32'h3F800000, 32'h40000000, 32'h40400000};
    run_pkt(0);
    check("tp_sum3_data", got_sum, 32'h40C00000);
    check("tp_sum3_flag", got_flag, 0);

    pkt = '{32'h3F800000};
    run_pkt(0);
    check("tp_single_data", got_sum, 32'h3F800000);
    check("tp_single_flag", got_flag, 0);

    pkt = '{32'h7F800000, 32'hFF800000};
    run_pkt(0);
    check("tp_inf_data", got_sum, 32'hFFC00000);
    check("tp_inf_flag", got_flag, 5'h10);

    pkt = '{32'h7F7FFFFF, 32'h7F7FFFFF};
    run_pkt(0);
    check("tp_ovf_data", got_sum, 32'h7F800000);
    check("tp_ovf_flag", got_flag, 5'h05);

    pkt = '{32'h3F800000, 32'h40000000};
    run_pkt(5);
    check("tp_bp_data", got_sum, 32'h40400000);

    pkt = '{32'h00000001, 32'h00000001};
    run_pkt(0);
`ifdef FADD_ACC_FTZ_EN
    check("tp_sub_data", got_sum, 32'h00000000);
`else
    check("tp_sub_data", got_sum, 32'h00000002);
`endif
    check("tp_sub_flag", got_flag, 0);

    // Reset pulse while the adder is in flight.
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h40000000;
    bus.in_last  = 1'b0;
    @(posedge clk); #1;
    bus.in_data  = 32'h3F800000;
    bus.in_last  = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    check("mid_wait_no_ready", bus.in_ready, 0);
    reset = 1'b0;
    #2;
    check_reset_vals("midrst");
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check_reset_vals("postrst");
    repeat (6) begin
      @(posedge clk); #1;
    end
    check("postrst_idle_valid", bus.out_valid, 0);
    pkt = '{32'h40000000, 32'h40000000};
    run_pkt(0);
    check("tp_rst_data", got_sum, 32'h40800000);
    check("tp_rst_flag", got_flag, 0);

    for (int p = 0; p < 25; p++) begin
      pkt.delete();
      repeat ($urandom_range(1, 6)) begin
        e = $urandom;
        if ($urandom_range(0, 3) == 0) e[30:23] = 8'h00;
        pkt.push_back(e);
      end
      run_pkt($urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fadd_acc.md
# fadd_acc

Streaming float32 accumulator that drives the pipelined single-precision adder (`fadd`) to reduce a packet of IEEE-754 values to one sum. It sits directly upstream of the adder, feeding `req`/`x`/`y`, and also consumes the adder's `rslt`/`flag`. It holds the running sum and sticky exception flags, and presents the final sum on a valid/ready output.

## Interface
- `LAT`, 3, cycles from the `add_req` cycle to the cycle in which `add_rslt`/`add_flag` are valid (≥1)
- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  input element valid
- `in_ready`  out  1  block can accept an element
- `in_data`  in  32  float32 element
- `in_last`  in  1  element is the last of the packet
- `out_valid`  out  1  sum valid
- `out_ready`  in  1  consumer accepts sum
- `out_data`  out  32  float32 sum
- `out_flag`  out  5  sticky flags {NV,DZ,OF,UF,NX}; DZ always 0
- `add_req`  out  1  one-cycle start to adder
- `add_x`, `add_y`  out  32 each  adder operands (registered)
- `add_rslt`  in  32  adder result
- `add_flag`  in  5  adder flags

## Operation
- State machine: IDLE → (ACCUM ↔ ISSUE → WAIT) → OUT → IDLE.
- IDLE: `in_ready`=1. On accept (`in_valid&in_ready`):
  - `acc`←`in_data`, `sticky`←0.
  - `in_last`=1 → OUT.
  - Otherwise → ACCUM.
- ACCUM: `in_ready`=1. On accept: `add_x`←`acc`, `add_y`←`in_data`, `last_q`←`in_last`; → ISSUE.
- ISSUE: `add_req`=1 for this cycle only; counter←LAT−1; → WAIT.
- WAIT: counter decrements each cycle. When it reaches 0, sample `add_rslt`/`add_flag` in that cycle:
  - `acc`←`add_rslt`, `sticky`←`sticky|add_flag`.
  - → OUT if `last_q`, else ACCUM.
- OUT: `out_valid`=1, `out_data`=`acc`, `out_flag`=`sticky`; held stable until `out_ready`. On `out_valid&out_ready` → IDLE.
- `add_x`/`add_y` are held constant from ISSUE through the capture cycle, because the adder re-reads its operands in its final stage for NaN/Inf checks.
- `in_ready`=0 in ISSUE, WAIT and OUT; there is no overlap between packets.
- Adder output is never used for single-element packets; the sum is the element bit-exact, flags 0.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `out_data`=0, `out_flag`=0, `add_req`=0, `add_x`=0, `add_y`=0; state IDLE; `acc`/`sticky` cleared.
- Element accepted in ACCUM at cycle t:
  - `add_req` is high in t+1.
  - Capture happens in cycle t+1+LAT (t+4 at default).
  - `in_ready` returns in t+2+LAT.
  - Per-element interval is LAT+2 (5) cycles.
- Last element accepted at cycle t: `out_valid` is asserted from t+2+LAT. For a single-element packet, it is asserted from t+1.
- `out_valid` may not drop without `out_ready`.
- Reset asserted mid-WAIT: all state is discarded and the in-flight adder result is ignored. After release, the block is in IDLE with reset values.
- `in_last` is sampled only on accept.

## Configuration
- `FADD_ACC_FTZ_EN` defined: flush-to-zero.
  - An accepted `in_data` with exp=0 and frac≠0 is replaced by the signed zero {sign,31'h0}.
  - A captured `add_rslt` with exp=0 and frac≠0 is replaced by the signed zero, and UF and NX are ORed into `sticky`.
- Undefined: subnormals pass through unchanged; flags come only from the adder.

## Test plan
- Packet 0x3F800000, 0x40000000, 0x40400000 (last) → `out_data`=0x40C00000, `out_flag`=0x00; `add_req` pulses exactly twice, 5 cycles apart.
- Single element 0x3F800000 with `in_last` → `out_data`=0x3F800000, `out_flag`=0x00, `out_valid` one cycle after accept, no `add_req`.
- 0x7F800000, 0xFF800000 (last) → 0xFFC00000, `out_flag`=0x10. 0x7F7FFFFF, 0x7F7FFFFF (last) → 0x7F800000, `out_flag`=0x05.
- Backpressure: `out_ready`=0 for 5 cycles in OUT → `out_data`/`out_flag` stable, `in_ready`=0 throughout; next packet accepted the cycle after the handshake.
- Reset pulse during WAIT → all outputs return to reset values; the following packet 0x40000000, 0x40000000 (last) → 0x40800000, flags 0.
- 0x00000001, 0x00000001 (last): macro undefined → 0x00000002, flags 0x00; `FADD_ACC_FTZ_EN` defined → 0x00000000, flags 0x00.
